cpu5_ctrl_seq: RTL
==================

# cpu5_ctrl_seq

Multi-cycle fetch/decode/execute/writeback sequencer for the 5-bit CPU, directly upstream of the ALU. It reads instruction words from an asynchronous-read program ROM, holds a 4×5-bit register file, and drives the ALU's `A`, `B` and `OP` inputs. It captures the ALU's `R`, `CF`, `SF` and `ZF` results, writes them back, and resolves conditional jumps from a latched flag register.

## Interface
- `PC_W`, default 5: program counter and ROM address width; PC wraps modulo 2^PC_W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: 1 permits leaving FETCH; 0 pauses in FETCH.
- `instr_addr` out PC_W: ROM address, equal to the PC.
- `instr_data` in 10: ROM word, combinational w.r.t. `instr_addr`.
- `alu_a`, `alu_b` out 5: ALU operands.
- `alu_op` out 2: ALU op encoding: 00 CMP (A−B), 10 ROL, 11 ADD.
- `alu_r` in 5, `alu_cf`/`alu_sf`/`alu_zf` in 1: ALU result and flags.
- `flags` out 3: latched {CF,SF,ZF}.
- `wb_en` out 1, `wb_addr` out 2, `wb_data` out 5: register-write strobe for observation.
- `halted` out 1: high once HLT executes.

## Operation
- Instruction format: [9:7] opcode, [6:5] rd, [4:3] rs, [4:0] imm5/addr5.
- Opcode 000 NOP.
- Opcode 001 LDI: rd ← imm5. Flags unchanged.
- Opcode 010 ADD: rd ← rd+rs. Flags updated.
- Opcode 011 CMP: computes rd−rs. Flags updated; no write.
- Opcode 100 ROL: rd ← ROL(rd,rs). Flags updated; CF as supplied by the ALU, which is 0.
- Opcode 101 JZ: if ZF then PC ← addr5. Zero-extended to PC_W, or truncated if PC_W<5.
- Opcode 110 JC: if CF then PC ← addr5.
- Opcode 111 HLT.
- States are FETCH, DECODE, EXEC, WB and HALT.
- FETCH:
  - If `run`=1: IR ← `instr_data`, PC ← PC+1, go to DECODE.
  - If `run`=0: hold, with no PC change.
- DECODE: operand latches ← regs[rd], regs[rs]. Go to EXEC.
- EXEC:
  - ALU ops: drive operands and op; capture `alu_r` and the flags at the edge. Go to WB.
  - LDI: go to WB.
  - JZ/JC: evaluate against `flags` as latched before this instruction; load PC if taken. Go to FETCH.
  - NOP: go to FETCH.
  - HLT: go to HALT.
- WB: regs[rd] ← captured result (ADD/ROL) or imm5 (LDI). `wb_en`=1 for this cycle only. CMP does not write. Go to FETCH.
- HALT: terminal. `halted`=1 until reset; `run` is ignored.
- Idle drive outside EXEC: `alu_a`=`alu_b`=0, `alu_op`=11.
- `run` dropping mid-instruction: the instruction completes, then the FSM pauses in FETCH.
- Register file: rd=rs is legal and reads the same value twice.

## Timing
- Reset values:
  - state FETCH, PC 0, `flags` 000, all regs 0.
  - `halted` 0, `wb_en` 0, `wb_addr` 0, `wb_data` 0.
  - `alu_a`/`alu_b` 0, `alu_op` 11.
- Latency, with `run` held high:
  - ALU ops and LDI: 4 cycles.
  - JZ/JC and NOP: 3 cycles.
  - HLT: 3 cycles to HALT.
- Register writes become visible to DECODE of the next instruction; there is no hazard logic.
- Flags written in EXEC of instruction N are used by a jump at N+1.
- PC increment at 2^PC_W−1 wraps to 0.
- An asserted `rst_n` in any state, including mid-EXEC, immediately restores all reset values. No partial write survives.

## Configuration
- `CPU5_RETIRE_CNT_EN` defined:
  - Adds output `retired` [7:0], reset 0.
  - Increments by 1 in the cycle the FSM re-enters FETCH or HALT after completing an instruction.
  - Wraps 255→0.
- Undefined: the port and its counter are absent, and all other behaviour is identical.

## Test plan
- Add: LDI r0,5; LDI r1,3; ADD r0,r1 → `wb_data`=8 at cycle 12, `flags`=000.
- Add carry-out: LDI r0,31; LDI r1,1; ADD r0,r1 → r0=0, `flags`=101 (CF=1, ZF=1).
- CMP and JZ taken: LDI r2,7; CMP r2,r2; JZ 6 → `flags` ZF=1, no `wb_en` during the CMP, PC=6 after the JZ.
- JC not taken: JC 20 with CF=0 → PC advances by 1. HLT → `halted`=1 and stays there under `run` toggling.
- PC wrap and pause: 32 NOPs with PC_W=5 → `instr_addr` returns to 0. With `run`=0 in FETCH, PC holds for 10 cycles.
- Reset mid-EXEC of ADD → next cycle all outputs are at reset values and regs are 0.
- With `CPU5_RETIRE_CNT_EN`: after the first scenario, `retired`=3.

Source files
------------

// File: rtl/cpu5_ctrl_seq_if.sv
// cpu5_ctrl_seq_if: bus between the cpu5 sequencer, its program ROM and the ALU.
// The master side is the sequencer. It drives the ROM address and the ALU
// operands/op. The slave side returns the ROM word and the ALU result and flags.
interface cpu5_ctrl_seq_if #(
  parameter int PC_W = 5
);
  logic [PC_W-1:0] instr_addr;
  logic [9:0]      instr_data;
  logic [4:0]      alu_a;
  logic [4:0]      alu_b;
  logic [1:0]      alu_op;
  logic [4:0]      alu_r;
  logic            alu_cf;
  logic            alu_sf;
  logic            alu_zf;

  modport master (
    output instr_addr,
    output alu_a,
    output alu_b,
    output alu_op,
    input  instr_data,
    input  alu_r,
    input  alu_cf,
    input  alu_sf,
    input  alu_zf
  );

  modport slave (
    input  instr_addr,
    input  alu_a,
    input  alu_b,
    input  alu_op,
    output instr_data,
    output alu_r,
    output alu_cf,
    output alu_sf,
    output alu_zf
  );
endinterface

// File: rtl/cpu5_ctrl_seq.sv
// cpu5_ctrl_seq: multi-cycle fetch/decode/execute/writeback sequencer for the
// 5-bit CPU. It fetches from an async-read ROM, keeps a 4x5-bit register file,
// drives the ALU and writes results back. Conditional jumps use the latched
// {CF,SF,ZF} flag register.
// Optional build macro CPU5_RETIRE_CNT_EN adds an 8-bit retired-instruction
// counter on output 'retired'.
module cpu5_ctrl_seq #(
  parameter int PC_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cpu5_ctrl_seq_if.master        bus,
  input  logic                   run,
  output logic [2:0]             flags,
  output logic                   wb_en,
  output logic [1:0]             wb_addr,
  output logic [4:0]             wb_data,
  output logic                   halted
`ifdef CPU5_RETIRE_CNT_EN
  ,
  output logic [7:0]             retired
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] ALU_CMP = 2'b00;
  localparam logic [1:0] ALU_ROL = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  // Architectural and pipeline-control registers with their next-state values.
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [9:0]      ir_q, ir_d;
  logic [4:0]      opA_q, opA_d;
  logic [4:0]      opB_q, opB_d;
  logic [4:0]      res_q, res_d;
  logic [2:0]      flags_q, flags_d;
  logic [4:0]      regs_q [4];
  logic [4:0]      regs_d [4];

  // Combinational ALU drive. It is idle (0, 0, ADD) unless an ALU op is executing.
  logic [4:0]      aluA;
  logic [4:0]      aluB;
  logic [1:0]      aluOp;

  // Instruction fields decoded from the instruction register.
  logic [2:0]      opcode;
  logic [1:0]      rd;
  logic [1:0]      rs;
  logic [4:0]      imm5;
  logic [PC_W-1:0] jmpTarget;

  assign opcode = ir_q[9:7];
  assign rd     = ir_q[6:5];
  assign rs     = ir_q[4:3];
  assign imm5   = ir_q[4:0];

  // The jump address is 5 bits. Fit it to the PC width by zero-extending or truncating.
  generate
    if (PC_W > 5) begin : gWideTarget
      assign jmpTarget = {{(PC_W-5){1'b0}}, imm5};
    end else begin : gNarrowTarget
      assign jmpTarget = imm5[PC_W-1:0];
    end
  endgenerate

  // State register plus all datapath registers. Reset clears everything, including mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

  // Next-state logic and per-state outputs. Everything holds and drives idle unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    res_d   = res_q;
    flags_d = flags_q;
    regs_d  = regs_q;
    aluA    = '0;
    aluB    = '0;
    aluOp   = ALU_ADD;
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;

    case (state_q)
      FETCH: begin
        if (run) begin
          ir_d    = bus.instr_data;
          pc_d    = pc_q + 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        opA_d   = regs_q[rd];
        opB_d   = regs_q[rs];
        state_d = EXEC;
      end

      EXEC: begin
        case (opcode)
          OP_ADD, OP_CMP, OP_ROL: begin
            aluA    = opA_q;
            aluB    = opB_q;
            aluOp   = (opcode == OP_ADD) ? ALU_ADD :
                      (opcode == OP_CMP) ? ALU_CMP : ALU_ROL;
            res_d   = bus.alu_r;
            flags_d = {bus.alu_cf, bus.alu_sf, bus.alu_zf};
            state_d = WB;
          end
          OP_LDI: begin
            res_d   = imm5;
            state_d = WB;
          end
          OP_JZ: begin
            if (flags_q[0]) begin
              pc_d = jmpTarget;
            end
            state_d = FETCH;
          end
          OP_JC: begin
            if (flags_q[2]) begin
              pc_d = jmpTarget;
            end
            state_d = FETCH;
          end
          OP_HLT: begin
            state_d = HALT;
          end
          default: begin
            state_d = FETCH;
          end
        endcase
      end

      WB: begin
        if (opcode != OP_CMP) begin
          regs_d[rd] = res_q;
          wb_en      = 1'b1;
          wb_addr    = rd;
          wb_data    = res_q;
        end
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.instr_addr = pc_q;
  assign bus.alu_a      = aluA;
  assign bus.alu_b      = aluB;
  assign bus.alu_op     = aluOp;
  assign flags          = flags_q;
  assign halted         = (state_q == HALT);

`ifdef CPU5_RETIRE_CNT_EN
  logic [7:0] retired_q, retired_d;
  logic       retireEvt;

  // An instruction retires when WB finishes or when EXEC returns straight to FETCH or HALT.
  always_comb begin
    retireEvt = (state_q == WB) || ((state_q == EXEC) && (state_d != WB));
    retired_d = retireEvt ? (retired_q + 8'd1) : retired_q;
  end

  // Retired-instruction counter. It wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule
